// File: rtl/bnn_pkg.sv
// Shared definitions for the MNIST BNN pipeline: top-level phase encodings,
// feature-map dimensions and index helpers for the flattened maps.
package bnn_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_LAYER_1 = 3'd2;
    localparam logic [2:0] S_LAYER_2 = 3'd3;
    localparam logic [2:0] S_LAYER_3 = 3'd4;

    localparam int L1_DIM   = 14;
    localparam int L1_CH    = 8;
    localparam int L2_DIM   = 7;
    localparam int L1_PLANE = L1_DIM * L1_DIM;
    localparam int L2_PLANE = L2_DIM * L2_DIM;
    localparam int L1_BITS  = L1_CH * L1_PLANE;

    // One 3x3 window across all input channels
    localparam int WIN_BITS = 9 * L1_CH;
    localparam int CNT_W    = $clog2(WIN_BITS + 1);

    // Layer-two sequencing phases
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FINISH = 2'd1,
        ST_DONE   = 2'd2
    } l2_state_e;

    // Bit position of (ch, r, c) in the 14x14x8 input map
    function automatic int l1_idx(input int ch, input int r, input int c);
        return ch * L1_PLANE + r * L1_DIM + c;
    endfunction

    // Bit position of (f, r, c) in the 7x7xF output map
    function automatic int l2_idx(input int f, input int r, input int c);
        return f * L2_PLANE + r * L2_DIM + c;
    endfunction

    // Bit position of a tap inside one filter's 72-bit kernel
    function automatic int w_idx(input int kr, input int kc, input int ch);
        return kr * 3 * L1_CH + kc * L1_CH + ch;
    endfunction

endpackage

// File: rtl/layer_two_if.sv
// Bus between the pipeline controller (master) and layer two (slave).
interface layer_two_if #(
    parameter int NUM_FILTERS = 16
);
    import bnn_pkg::*;

    logic [2:0]                         state;
    logic [L1_BITS-1:0]                 fmap_in;
    logic [NUM_FILTERS*L2_PLANE-1:0]    layer_two_out;
    logic                               done;

    modport master (
        output state,
        output fmap_in,
        input  layer_two_out,
        input  done
    );

    modport slave (
        input  state,
        input  fmap_in,
        output layer_two_out,
        output done
    );

endinterface

// File: rtl/bnn_xnor_popcount.sv
// Combinational XNOR-popcount: number of positions where data equals weight.
module bnn_xnor_popcount #(
    parameter int WIDTH = 72
) (
    input  logic [WIDTH-1:0]               i_data,
    input  logic [WIDTH-1:0]               i_weight,
    output logic [$clog2(WIDTH+1)-1:0]     o_count
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] w_count;

    // Sum the per-bit agreement flags
    always_comb begin
        w_count = {CW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            w_count = w_count + {{(CW-1){1'b0}}, ~(i_data[i] ^ i_weight[i])};
        end
    end

    assign o_count = w_count;

endmodule

// File: rtl/layer_two.sv
// Second binary convolution layer: 3x3x8 XNOR-popcount per filter with zero
// padding, per-filter threshold, 2x2 OR max-pool, one window per active cycle.
module layer_two
    import bnn_pkg::*;
#(
    parameter int                           NUM_FILTERS = 16,
    parameter logic [NUM_FILTERS*72-1:0]    WEIGHTS2    = '0,
    parameter logic [NUM_FILTERS*7-1:0]     THRESHOLDS  = {NUM_FILTERS{7'd36}}
) (
    input  logic        clk,
    input  logic        rst_n,
    layer_two_if.slave  bus
);

    localparam int          OUT_W  = NUM_FILTERS * L2_PLANE;
    localparam logic [4:0]  LAST_F = 5'(NUM_FILTERS - 1);
    localparam logic [4:0]  NUM_F  = 5'(NUM_FILTERS);

    // Sequencing state
    l2_state_e          r_fsm,      w_fsm_next;
    logic [4:0]         r_filter,   w_filter_next;
    logic [2:0]         r_row,      w_row_next;
    logic [2:0]         r_col,      w_col_next;
    logic [1:0]         r_pool_cnt, w_pool_cnt_next;
    logic               r_pool_acc, w_pool_acc_next;
    logic [OUT_W-1:0]   r_out,      w_out_next;
    logic               r_done,     w_done_next;

    // Datapath
    logic               w_active;
    logic [4:0]         w_fsel;
    logic [WIN_BITS-1:0] w_win;
    logic [WIN_BITS-1:0] w_weight;
    logic [6:0]         w_thr;
    logic [CNT_W-1:0]   w_count;
    logic               w_bit;
    logic               w_pooled;

    assign w_active = (bus.state == S_LAYER_2);
    // Once every filter is done the counter sits at NUM_FILTERS; keep the
    // parameter selects in range by falling back to filter 0 there.
    assign w_fsel   = (r_filter < NUM_F) ? r_filter : 5'd0;
    assign w_weight = WEIGHTS2[int'(w_fsel)*WIN_BITS +: WIN_BITS];
    assign w_thr    = THRESHOLDS[int'(w_fsel)*7 +: 7];

    // Gather the 3x3x8 window around the current pool position; off-map taps read 0
    always_comb begin : gather
        int pr;
        int pc;
        int tr;
        int tc;
        w_win = '0;
        pr = 2 * int'(r_row) + int'(r_pool_cnt[1]);
        pc = 2 * int'(r_col) + int'(r_pool_cnt[0]);
        for (int kr = 0; kr < 3; kr++) begin
            for (int kc = 0; kc < 3; kc++) begin
                tr = pr + kr - 1;
                tc = pc + kc - 1;
                for (int ch = 0; ch < L1_CH; ch++) begin
                    if (tr >= 0 && tr < L1_DIM && tc >= 0 && tc < L1_DIM) begin
                        w_win[w_idx(kr, kc, ch)] = bus.fmap_in[l1_idx(ch, tr, tc)];
                    end else begin
                        w_win[w_idx(kr, kc, ch)] = 1'b0;
                    end
                end
            end
        end
    end

    bnn_xnor_popcount #(
        .WIDTH (WIN_BITS)
    ) u_popcount (
        .i_data   (w_win),
        .i_weight (w_weight),
        .o_count  (w_count)
    );

    assign w_bit    = (w_count > w_thr);
    assign w_pooled = r_pool_acc | w_bit;

    // Next-state: pool accumulate, result write, counter advance and completion
    always_comb begin
        w_fsm_next      = r_fsm;
        w_filter_next   = r_filter;
        w_row_next      = r_row;
        w_col_next      = r_col;
        w_pool_cnt_next = r_pool_cnt;
        w_pool_acc_next = r_pool_acc;
        w_out_next      = r_out;
        w_done_next     = r_done;
        if (w_active) begin
            case (r_fsm)
                ST_RUN: begin
                    if (r_pool_cnt != 2'd3) begin
                        w_pool_acc_next = w_pooled;
                        w_pool_cnt_next = r_pool_cnt + 2'd1;
                    end else begin
                        w_out_next[l2_idx(int'(r_filter), int'(r_row), int'(r_col))] = w_pooled;
                        w_pool_acc_next = 1'b0;
                        w_pool_cnt_next = 2'd0;
                        if (r_col != 3'd6) begin
                            w_col_next = r_col + 3'd1;
                        end else begin
                            w_col_next = 3'd0;
                            if (r_row != 3'd6) begin
                                w_row_next = r_row + 3'd1;
                            end else begin
                                w_row_next    = 3'd0;
                                w_filter_next = r_filter + 5'd1;
                                if (r_filter == LAST_F) begin
                                    w_fsm_next = ST_FINISH;
                                end else begin
                                    w_fsm_next = ST_RUN;
                                end
                            end
                        end
                    end
                end
                ST_FINISH: begin
                    w_done_next = 1'b1;
                    w_fsm_next  = ST_DONE;
                end
                ST_DONE: begin
                    w_done_next = 1'b1;
                    w_fsm_next  = ST_DONE;
                end
                default: begin
                    // Recover from an illegal code using the counters as truth
                    if (r_filter < NUM_F) begin
                        w_fsm_next = ST_RUN;
                    end else begin
                        w_fsm_next = ST_FINISH;
                    end
                end
            endcase
        end else begin
            // Paused: everything holds so the run resumes where it stopped
            w_fsm_next = r_fsm;
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm      <= ST_RUN;
            r_filter   <= 5'd0;
            r_row      <= 3'd0;
            r_col      <= 3'd0;
            r_pool_cnt <= 2'd0;
            r_pool_acc <= 1'b0;
            r_out      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_fsm      <= w_fsm_next;
            r_filter   <= w_filter_next;
            r_row      <= w_row_next;
            r_col      <= w_col_next;
            r_pool_cnt <= w_pool_cnt_next;
            r_pool_acc <= w_pool_acc_next;
            r_out      <= w_out_next;
            r_done     <= w_done_next;
        end
    end

    assign bus.layer_two_out = r_out;
    assign bus.done          = r_done;

endmodule

// File: tb/tb_layer_two.sv
// Directed bench for layer_two: reset/idle, constant maps, single pixel,
// pause and mid-run restart against a reference model of the layer.
module tb_layer_two;
    import bnn_pkg::*;

    localparam logic [1151:0] W_ONES = {1152{1'b1}};
    localparam logic [1151:0] W_ZERO = {1152{1'b0}};
    localparam logic [143:0]  W_PIX  = 144'h1_0000_0000;     // filter 0, kr=1 kc=1 ch0
    localparam logic [13:0]   TH_PIX = {7'd36, 7'd71};
    localparam logic [1151:0] W_RND  = {
        72'h9E_3779_B97F_4A7C_15F1, 72'h3C_6EF3_72FE_94F8_2A61, 72'hA5_4FF5_3A5F_1D36_F1C4,
        72'h51_0E52_7FAD_E682_D1E3, 72'h9B_0568_8C2B_3E6C_1F07, 72'h1F_83D9_ABFB_41BD_6B55,
        72'h5B_E0CD_19C3_7E2F_9A18, 72'hC1_0596_D8A2_4F3B_7E60, 72'h27_D4EB_2F16_5667_C5B9,
        72'hD6_E8FE_B868_0E4A_3D72, 72'h4A_7484_AA6F_9C11_8B2E, 72'h8F_1BBC_DCC3_5A47_E904,
        72'h6A_09E6_67F3_BCC9_08B2, 72'hE3_9A7C_0D51_2F84_76AB, 72'h0B_75F2_C4E8_9D13_A65C,
        72'h72_C19F_3E05_B8D6_4A91};
    localparam logic [111:0]  TH_RND = {
        7'd38, 7'd35, 7'd40, 7'd33, 7'd37, 7'd41, 7'd34, 7'd39,
        7'd36, 7'd42, 7'd35, 7'd38, 7'd33, 7'd40, 7'd37, 7'd36};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_a, rst_b;
    logic [2:0]     st_a, st_b;
    logic [1567:0]  fm_a, fm_pix, fm_b;

    int total = 0;
    int bad   = 0;
    int cur   = 0;

    layer_two_if #(.NUM_FILTERS(16)) if_zero ();
    layer_two_if #(.NUM_FILTERS(16)) if_ones ();
    layer_two_if #(.NUM_FILTERS(2))  if_pix  ();
    layer_two_if #(.NUM_FILTERS(16)) if_rnd  ();

    assign if_zero.state = st_a;  assign if_zero.fmap_in = fm_a;
    assign if_ones.state = st_a;  assign if_ones.fmap_in = fm_a;
    assign if_pix.state  = st_a;  assign if_pix.fmap_in  = fm_pix;
    assign if_rnd.state  = st_b;  assign if_rnd.fmap_in  = fm_b;

    layer_two #(.NUM_FILTERS(16), .WEIGHTS2(W_ZERO), .THRESHOLDS({16{7'd36}}))
        u_zero (.clk(clk), .rst_n(rst_a), .bus(if_zero));
    layer_two #(.NUM_FILTERS(16), .WEIGHTS2(W_ONES), .THRESHOLDS({16{7'd36}}))
        u_ones (.clk(clk), .rst_n(rst_a), .bus(if_ones));
    layer_two #(.NUM_FILTERS(2), .WEIGHTS2(W_PIX), .THRESHOLDS(TH_PIX))
        u_pix (.clk(clk), .rst_n(rst_a), .bus(if_pix));
    layer_two #(.NUM_FILTERS(16), .WEIGHTS2(W_RND), .THRESHOLDS(TH_RND))
        u_rnd (.clk(clk), .rst_n(rst_b), .bus(if_rnd));

    task automatic chk(input string tag, input logic [799:0] got, input logic [799:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // Advance to just after active edge number 'target' of the current run
    task automatic run_to(input int target);
        while (cur < target) begin
            @(posedge clk);
            cur++;
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: direct evaluation of every pooled output bit
    function automatic logic [783:0] golden(input logic [1567:0] fm,
                                            input logic [1151:0] w,
                                            input logic [111:0]  th);
        logic [783:0] res;
        res = '0;
        for (int f = 0; f < 16; f++) begin
            for (int r = 0; r < 7; r++) begin
                for (int c = 0; c < 7; c++) begin
                    logic acc;
                    acc = 1'b0;
                    for (int p = 0; p < 4; p++) begin
                        int cnt;
                        int pr;
                        int pc;
                        cnt = 0;
                        pr  = 2 * r + p / 2;
                        pc  = 2 * c + p % 2;
                        for (int kr = 0; kr < 3; kr++) begin
                            for (int kc = 0; kc < 3; kc++) begin
                                for (int ch = 0; ch < 8; ch++) begin
                                    int  tr;
                                    int  tc;
                                    logic d;
                                    tr = pr + kr - 1;
                                    tc = pc + kc - 1;
                                    if (tr < 0 || tr > 13 || tc < 0 || tc > 13) d = 1'b0;
                                    else d = fm[ch*196 + tr*14 + tc];
                                    if (d == w[f*72 + kr*24 + kc*8 + ch]) cnt++;
                                end
                            end
                        end
                        if (cnt > int'(th[f*7 +: 7])) acc = 1'b1;
                    end
                    res[f*49 + r*7 + c] = acc;
                end
            end
        end
        return res;
    endfunction

    logic [783:0] exp_map;
    logic [783:0] snap;
    logic [783:0] mask250;

    initial begin
        rst_a  = 1'b0;
        rst_b  = 1'b0;
        st_a   = S_IDLE;
        st_b   = S_IDLE;
        fm_a   = '0;
        fm_pix = '0;
        fm_pix[0] = 1'b1;
        fm_b   = '0;
        #1;
        tick();
        tick();
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Reset state
        chk("rst_zero_out", 800'(if_zero.layer_two_out), 800'd0);
        chk("rst_zero_done", 800'(if_zero.done), 800'd0);
        chk("rst_rnd_out", 800'(if_rnd.layer_two_out), 800'd0);

        // Idle keeps everything cleared
        repeat (50) tick();
        chk("idle_zero_out", 800'(if_zero.layer_two_out), 800'd0);
        chk("idle_zero_done", 800'(if_zero.done), 800'd0);
        chk("idle_pix_out", 800'(if_pix.layer_two_out), 800'd0);
        chk("idle_rnd_done", 800'(if_rnd.done), 800'd0);

        // Group A: constant maps and single pixel, state held from edge 1
        st_a = S_LAYER_2;
        cur  = 0;
        run_to(3);
        chk("zero_e3_out", 800'(if_zero.layer_two_out), 800'd0);
        run_to(4);
        chk("zero_e4_out", 800'(if_zero.layer_two_out), 800'd1);
        run_to(392);
        chk("pix_map", 800'(if_pix.layer_two_out), 800'({{49{1'b1}}, {48{1'b0}}, 1'b1}));
        chk("pix_done_392", 800'(if_pix.done), 800'd0);
        run_to(393);
        chk("pix_done_393", 800'(if_pix.done), 800'd1);
        run_to(3136);
        chk("zero_map", 800'(if_zero.layer_two_out), 800'({784{1'b1}}));
        chk("zero_done_3136", 800'(if_zero.done), 800'd0);
        chk("ones_map", 800'(if_ones.layer_two_out), 800'd0);
        chk("ones_done_3136", 800'(if_ones.done), 800'd0);
        run_to(3137);
        chk("zero_done_3137", 800'(if_zero.done), 800'd1);
        chk("ones_done_3137", 800'(if_ones.done), 800'd1);

        // done is sticky across other phases
        st_a = S_LAYER_3;
        repeat (20) tick();
        chk("zero_done_sticky", 800'(if_zero.done), 800'd1);
        chk("zero_map_hold", 800'(if_zero.layer_two_out), 800'({784{1'b1}}));
        chk("pix_map_hold", 800'(if_pix.layer_two_out), 800'({{49{1'b1}}, {48{1'b0}}, 1'b1}));
        rst_a = 1'b0;
        tick();
        chk("zero_rst_out", 800'(if_zero.layer_two_out), 800'd0);
        chk("zero_rst_done", 800'(if_zero.done), 800'd0);
        rst_a = 1'b1;

        // Group B: mid-run reset at edge 2000, then full run
        for (int i = 0; i < 49; i++) fm_b[i*32 +: 32] = $urandom();
        exp_map = golden(fm_b, W_RND, TH_RND);
        st_b = S_LAYER_2;
        cur  = 0;
        run_to(2000);
        chk("rnd_pre_rst_nonzero", 800'(if_rnd.layer_two_out != 784'd0 || exp_map[499:0] == 500'd0), 800'd1);
        rst_b = 1'b0;
        tick();
        chk("rnd_midrst_out", 800'(if_rnd.layer_two_out), 800'd0);
        chk("rnd_midrst_done", 800'(if_rnd.done), 800'd0);
        rst_b = 1'b1;
        cur   = 0;
        run_to(3136);
        chk("rnd_restart_map", 800'(if_rnd.layer_two_out), 800'(exp_map));
        chk("rnd_restart_done_3136", 800'(if_rnd.done), 800'd0);
        run_to(3137);
        chk("rnd_restart_done_3137", 800'(if_rnd.done), 800'd1);

        // Group B: pause for 100 cycles at edge 1000 with a new map
        rst_b = 1'b0;
        for (int i = 0; i < 49; i++) fm_b[i*32 +: 32] = $urandom();
        tick();
        rst_b   = 1'b1;
        exp_map = golden(fm_b, W_RND, TH_RND);
        mask250 = (784'd1 << 250) - 784'd1;
        cur     = 0;
        run_to(1000);
        chk("rnd_partial_1000", 800'(if_rnd.layer_two_out), 800'(exp_map & mask250));
        snap = if_rnd.layer_two_out;
        st_b = S_IDLE;
        run_to(1100);
        chk("rnd_pause_hold", 800'(if_rnd.layer_two_out), 800'(snap));
        chk("rnd_pause_done", 800'(if_rnd.done), 800'd0);
        st_b = S_LAYER_2;
        run_to(3236);
        chk("rnd_pause_map", 800'(if_rnd.layer_two_out), 800'(exp_map));
        chk("rnd_pause_done_3236", 800'(if_rnd.done), 800'd0);
        run_to(3237);
        chk("rnd_pause_done_3237", 800'(if_rnd.done), 800'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/layer_two.md
# layer_two

Second binary convolution stage of the MNIST BNN. It reads the 14x14x8 binary feature map produced by the first layer and computes, one window per clock, a 3x3x8 XNOR-popcount convolution for each of NUM_FILTERS filters with zero padding. It then applies a per-filter threshold and a 2x2 max-pool (OR), and writes a 7x7xNUM_FILTERS binary map for the third layer.

## Interface
- NUM_FILTERS, 16, number of output filters (1..16)
- WEIGHTS2, all zeros, NUM_FILTERS*72 bits; bit f*72 + kr*24 + kc*8 + ch is the weight of filter f, kernel row kr, kernel col kc, input channel ch
- THRESHOLDS, 36 in every field, NUM_FILTERS*7 bits; field f is bits [f*7+6 : f*7], the unsigned popcount threshold of filter f
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- state  in  3  top-level phase; the block computes only when state == S_LAYER_2 (3'b011)
- fmap_in  in  1568  input map; bit ch*196 + r*14 + c; must be stable while state == S_LAYER_2
- layer_two_out  out  NUM_FILTERS*49  output map; bit f*49 + r*7 + c
- done  out  1  sticky completion flag

## Operation
- Registers:
  - filter: 0..NUM_FILTERS
  - row, col: 0..6
  - pool_cnt: 2 bits
  - pool_acc: 1 bit
- Pool position: pr = 2*row + pool_cnt[1], pc = 2*col + pool_cnt[0].
- Window: taps (pr+kr-1, pc+kc-1) for kr, kc in 0..2, across all 8 channels. A tap outside 0..13 reads as 0 and is still XNORed with its weight.
- Conv bit: popcount over the 72 XNOR results (7-bit unsigned). The bit is 1 when popcount > THRESHOLDS[filter] (strict).
- Each active cycle, while filter < NUM_FILTERS:
  - pool_cnt < 3: pool_acc <= pool_acc | bit; pool_cnt++.
  - pool_cnt == 3: layer_two_out[filter*49 + row*7 + col] <= pool_acc | bit; pool_cnt, pool_acc <= 0; advance col.
  - col wraps 6→0 with row++. On row 6 / col 6, row and col go to 0 and filter++.
- Active cycle with filter == NUM_FILTERS: done <= 1. Counters hold.
- State machine, derived from the counters:
  - RUN: filter < NUM_FILTERS.
  - FINISH: filter == NUM_FILTERS and done == 0.
  - DONE: done == 1.
  - DONE is left only by reset.
- state != S_LAYER_2: all registers hold (pause). Computation resumes exactly where it stopped.
- Output bits not yet written keep their reset value 0.

## Timing
- Reset: layer_two_out = 0, done = 0, and all counters = 0. Reset takes priority over everything, including mid-run; the run restarts from filter 0.
- Combinational path: fmap/counter → conv bit. The only register stage is the result write. Latency is 4 cycles per output bit.
- With state held at S_LAYER_2 from active edge 1:
  - The bit (f, r, c) is written on edge 4*(f*49 + r*7 + c) + 4.
  - The last bit is written on edge 196*NUM_FILTERS (3136 for the default).
  - done rises on edge 196*NUM_FILTERS + 1 (3137).
- Paused cycles add 1:1 to every edge count.
- done stays high across any later state value until rst_n is asserted.

## Structure
- Shared package bnn_pkg:
  - State encodings S_IDLE=0, S_LOAD=1, S_LAYER_1=2, S_LAYER_2=3, S_LAYER_3=4.
  - Map dimensions L1_DIM=14, L1_CH=8, L2_DIM=7.
  - Index helper functions for the flattened maps.
- Sub-module bnn_xnor_popcount, parameter WIDTH (72 here):
  - Inputs: data and weight vectors.
  - Output: the popcount of their XNOR, $clog2(WIDTH+1) bits.
  - Purely combinational.
- layer_two holds the window gather (with padding), the threshold compare, the counters and the output register.

## Test plan
1. **Reset:** drive rst_n=0 mid-run with random fmap → layer_two_out == 0 and done == 0 on the next edge; with state == S_IDLE, outputs stay 0 indefinitely.
2. **All-zero fmap, all-zero weights, THRESHOLDS = 36:** every popcount is 72 → all 784 bits = 1; done rises on edge 3137, not earlier.
3. **All-zero fmap, all-ones weights:** every popcount is 0 → layer_two_out == 0; done rises on edge 3137.
4. **Single pixel:**
   - Setup: fmap bit 0 only (ch0, r0, c0) set; filter 0 weight only at kr=1, kc=1, ch0; THRESHOLDS[0] = 71.
   - Expected: layer_two_out[0] == 1; bits 1..48 == 0.
   - Covers padding, indexing and strict compare.
5. **Pause:** random fmap and weights; force state to S_IDLE for 100 cycles at edge 1000 → final map is identical to the golden model; done rises on edge 3237.
6. **Restart:** assert rst_n for 1 cycle at edge 2000, then continue in S_LAYER_2 → outputs clear, then match the golden model; done rises 3137 active edges after reset release.
